// File: rtl/screen_streamer.sv
// screen_streamer
// Reads a 64x32 monochrome framebuffer and sends it out as a 128x64
// SSD1306-format byte stream. Each framebuffer pixel becomes a 2x2 block.
//
// One framebuffer byte column (bx) of one page uses four framebuffer rows.
// Those four rows make one group. The streamer loads a group into row_buf
// with four reads (LOAD). It then emits the 16 display columns covered by
// those 8 pixels (EMIT). This repeats for 8 byte columns x 8 pages, giving
// 1024 bytes per frame.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   start          request one full frame (ignored while busy)
//   busy           high whenever the streamer is not idle
//   mem_read       framebuffer read request (LOAD only)
//   mem_read_idx   framebuffer byte address (0 outside LOAD)
//   mem_read_byte  read data, valid in the mem_read_ack cycle
//   mem_read_ack   read completion strobe
//   out_valid      out_byte is valid (EMIT only)
//   out_byte       display byte, bit k = display row 8*page+k
//   out_last       marks the final byte of the frame
//   out_ready      downstream accepts; a transfer is out_valid & out_ready
module screen_streamer #(
    parameter logic [11:0] FB_BASE = 12'h100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        mem_read,
    output logic [11:0] mem_read_idx,
    input  logic [7:0]  mem_read_byte,
    input  logic        mem_read_ack,
    output logic        out_valid,
    output logic [7:0]  out_byte,
    output logic        out_last,
    input  logic        out_ready
);

    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

    state_t     state;
    logic [2:0] page;
    logic [2:0] bx;
    logic [1:0] r;
    logic [3:0] j;
    logic [7:0] row_buf [4];

    // Build one display byte from the four buffered rows. Every output
    // column pair (j, j+1) shows the same source pixel, and every
    // framebuffer row fills two adjacent display rows.
    function automatic logic [7:0] scale_byte(input logic [7:0] b0,
                                              input logic [7:0] b1,
                                              input logic [7:0] b2,
                                              input logic [7:0] b3,
                                              input logic [3:0] col);
        logic [2:0] px;
        px = 3'd7 - col[3:1];
        return {b3[px], b3[px], b2[px], b2[px], b1[px], b1[px], b0[px], b0[px]};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            page  <= '0;
            bx    <= '0;
            r     <= '0;
            j     <= '0;
            for (int i = 0; i < 4; i++) row_buf[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        page  <= '0;
                        bx    <= '0;
                        r     <= '0;
                        j     <= '0;
                    end
                end
                LOAD: begin
                    if (mem_read_ack) begin
                        row_buf[r] <= mem_read_byte;
                        if (r == 2'd3) begin
                            r     <= '0;
                            state <= EMIT;
                        end else begin
                            r <= r + 2'd1;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (j == 4'd15) begin
                            j  <= '0;
                            bx <= bx + 3'd1;
                            if (bx == 3'd7) page <= page + 3'd1;
                            // Counters wrap to zero on the final byte, so IDLE
                            // is entered with clean counters.
                            if (bx == 3'd7 && page == 3'd7) state <= IDLE;
                            else                            state <= LOAD;
                        end else begin
                            j <= j + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded only from registered state. mem_read also depends on
    // the ack, so that the request drops in the completion cycle.
    always_comb begin
        busy         = (state != IDLE);
        mem_read     = 1'b0;
        mem_read_idx = '0;
        out_valid    = 1'b0;
        out_byte     = '0;
        out_last     = 1'b0;
        if (state == LOAD) begin
            mem_read     = !mem_read_ack;
            mem_read_idx = FB_BASE + {4'd0, page, 5'd0} + {7'd0, r, 3'd0} + {9'd0, bx};
        end
        if (state == EMIT) begin
            out_valid = 1'b1;
            out_byte  = scale_byte(row_buf[0], row_buf[1], row_buf[2], row_buf[3], j);
            out_last  = (page == 3'd7) && (bx == 3'd7) && (j == 4'd15);
        end
    end

endmodule

// File: tb/tb_screen_streamer.sv
module tb_screen_streamer;

    localparam logic [11:0] BASE = 12'h100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        mem_read;
    logic [11:0] mem_read_idx;
    logic [7:0]  mem_read_byte = 8'h00;
    logic        mem_read_ack = 1'b0;
    logic        out_valid;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        out_ready = 1'b1;

    screen_streamer #(.FB_BASE(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .mem_read(mem_read), .mem_read_idx(mem_read_idx),
        .mem_read_byte(mem_read_byte), .mem_read_ack(mem_read_ack),
        .out_valid(out_valid), .out_byte(out_byte), .out_last(out_last),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Framebuffer memory model with a configurable number of wait cycles
    logic [7:0]  mem [0:4095];
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    bit          req_open  = 0;
    bit          idx_changed = 0;
    logic [11:0] req_idx = '0;

    always begin
        @(negedge clk);
        if (mem_read) begin
            if (!req_open) begin
                req_open = 1;
                req_idx  = mem_read_idx;
                wait_cnt = 0;
            end else if (mem_read_idx !== req_idx) begin
                idx_changed = 1;
            end
            if (wait_cnt >= ack_delay) begin
                mem_read_ack  = 1'b1;
                mem_read_byte = mem[mem_read_idx];
                @(posedge clk);
                #1;
                mem_read_ack  = 1'b0;
                mem_read_byte = 8'h00;
                req_open      = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            req_open = 0;
        end
    end

    // Output capture
    logic [7:0] cap_byte [0:2047];
    logic       cap_last [0:2047];
    int cap_n = 0, last_cnt = 0, last_pos = -1, last_cyc = -1;

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (cap_n < 2048) begin
                cap_byte[cap_n] = out_byte;
                cap_last[cap_n] = out_last;
            end
            if (out_last) begin
                last_cnt++;
                last_pos = cap_n;
                last_cyc = cyc;
            end
            cap_n++;
        end
    end

    // Reference: display byte n comes from page n/128 and display column n%128.
    // Display row y shows framebuffer row y/2, and display column c shows pixel
    // c/2.
    function automatic logic [7:0] exp_byte(int n);
        logic [7:0] b;
        int pg, x, y, addr;
        pg = n / 128;
        x  = (n % 128) / 2;
        for (int k = 0; k < 8; k++) begin
            y    = 8 * pg + k;
            addr = int'(BASE) + (y / 2) * 8 + x / 8;
            b[k] = mem[addr][7 - (x % 8)];
        end
        return b;
    endfunction

    function automatic int frame_errs(output int first_bad);
        int e;
        e = 0;
        first_bad = -1;
        for (int n = 0; n < 1024; n++) begin
            if (cap_byte[n] !== exp_byte(n)) begin
                if (first_bad < 0) first_bad = n;
                e++;
            end
        end
        return e;
    endfunction

    task automatic clear_capture();
        cap_n = 0; last_cnt = 0; last_pos = -1; last_cyc = -1;
    endtask

    task automatic fill_zero();
        for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(output bit timed_out, output int fall_cyc);
        timed_out = 1;
        fall_cyc  = -1;
        for (int i = 0; i < 10000; i++) begin
            if (!busy) begin
                timed_out = 0;
                fall_cyc  = cyc;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        fill_zero();
        reset = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, mem_read, out_valid, out_last} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/rd/vld/last=%b expected 0000", {busy, mem_read, out_valid, out_last});
        end
        n_checks++;
        if ({mem_read_idx, out_byte} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_data: idx=%h byte=%h expected 0", mem_read_idx, out_byte);
        end
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_latency();
        bit to; int fc;
        fill_zero();
        ack_delay = 0;
        clear_capture();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (mem_read !== 1'b1 || mem_read_idx !== BASE) begin
            n_fail++;
            $display("FAIL latency_read: mem_read=%b idx=%h expected 1 %h", mem_read, mem_read_idx, BASE);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: out_valid=%b at N+4 expected 0", out_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_valid: out_valid=%b at N+5 expected 1", out_valid);
        end
        wait_idle(to, fc);
        n_checks++;
        if (to || cap_n !== 1024) begin
            n_fail++;
            $display("FAIL latency_frame: timeout=%0d count=%0d expected 0 1024", to, cap_n);
        end
    endtask

    task automatic test_zero_frame();
        bit to; int fc, fb, e;
        fill_zero();
        ack_delay = 0;
        clear_capture();
        pulse_start();
        wait_idle(to, fc);
        n_checks++;
        if (to || cap_n !== 1024) begin
            n_fail++;
            $display("FAIL zero_count: timeout=%0d count=%0d expected 0 1024", to, cap_n);
        end
        e = frame_errs(fb);
        n_checks++;
        if (e !== 0) begin
            n_fail++;
            $display("FAIL zero_data: %0d bad bytes, first at %0d got %h expected 00", e, fb, cap_byte[fb]);
        end
        n_checks++;
        if (last_cnt !== 1 || last_pos !== 1023) begin
            n_fail++;
            $display("FAIL zero_last: count=%0d pos=%0d expected 1 1023", last_cnt, last_pos);
        end
        n_checks++;
        if (fc !== last_cyc + 1) begin
            n_fail++;
            $display("FAIL zero_busy_drop: busy low at cycle %0d expected %0d", fc, last_cyc + 1);
        end
    endtask

    task automatic test_pixel_first();
        bit to; int fc, fb, e;
        fill_zero();
        mem[12'h100] = 8'h80;
        clear_capture();
        pulse_start();
        wait_idle(to, fc);
        n_checks++;
        if (cap_byte[0] !== 8'h03 || cap_byte[1] !== 8'h03 || cap_byte[2] !== 8'h00) begin
            n_fail++;
            $display("FAIL pixel_first: bytes0..2=%h %h %h expected 03 03 00", cap_byte[0], cap_byte[1], cap_byte[2]);
        end
        e = frame_errs(fb);
        n_checks++;
        if (to || cap_n !== 1024 || e !== 0) begin
            n_fail++;
            $display("FAIL pixel_first_frame: count=%0d errs=%0d first=%0d expected 1024 0", cap_n, e, fb);
        end
    endtask

    task automatic test_pixel_last();
        bit to; int fc, fb, e;
        fill_zero();
        mem[12'h1FF] = 8'h01;
        clear_capture();
        pulse_start();
        wait_idle(to, fc);
        n_checks++;
        if (cap_byte[1022] !== 8'hC0 || cap_byte[1023] !== 8'hC0 || cap_byte[1021] !== 8'h00) begin
            n_fail++;
            $display("FAIL pixel_last: bytes1021..1023=%h %h %h expected 00 C0 C0", cap_byte[1021], cap_byte[1022], cap_byte[1023]);
        end
        e = frame_errs(fb);
        n_checks++;
        if (to || cap_n !== 1024 || e !== 0) begin
            n_fail++;
            $display("FAIL pixel_last_frame: count=%0d errs=%0d first=%0d expected 1024 0", cap_n, e, fb);
        end
    endtask

    task automatic test_stall_pattern();
        bit to, found, unstable; int fc, fb, e;
        logic [7:0] hb; logic hl;
        fill_zero();
        for (int a = 0; a < 256; a++) mem[int'(BASE) + a] = 8'($urandom_range(0, 255));
        ack_delay   = 3;
        idx_changed = 0;
        clear_capture();
        pulse_start();
        found = 0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(posedge clk); #1;
            if (cap_n >= 300 && out_valid) found = 1;
        end
        unstable = 0;
        if (found) begin
            out_ready = 1'b0;
            hb = out_byte;
            hl = out_last;
            repeat (5) begin
                @(negedge clk);
                if (out_byte !== hb || out_last !== hl || out_valid !== 1'b1) unstable = 1;
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
        end
        n_checks++;
        if (!found || unstable) begin
            n_fail++;
            $display("FAIL stall_hold: reached=%0d unstable=%0d expected 1 0", found, unstable);
        end
        wait_idle(to, fc);
        e = frame_errs(fb);
        n_checks++;
        if (to || cap_n !== 1024 || e !== 0) begin
            n_fail++;
            $display("FAIL stall_frame: count=%0d errs=%0d first=%0d expected 1024 0", cap_n, e, fb);
        end
        n_checks++;
        if (idx_changed !== 1'b0 || last_cnt !== 1) begin
            n_fail++;
            $display("FAIL stall_idx_last: idx_changed=%0d last_count=%0d expected 0 1", idx_changed, last_cnt);
        end
        ack_delay = 0;
    endtask

    task automatic test_reset_mid();
        bit to, found; int fc, fb, e;
        clear_capture();
        pulse_start();
        found = 0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(posedge clk); #1;
            if (cap_n >= 500 && out_valid) found = 1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (!found || {busy, out_valid, mem_read} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid: reached=%0d busy/vld/rd=%b expected 1 000", found, {busy, out_valid, mem_read});
        end
        reset = 1'b0;
        clear_capture();
        pulse_start();
        wait_idle(to, fc);
        e = frame_errs(fb);
        n_checks++;
        if (to || cap_n !== 1024 || e !== 0 || last_pos !== 1023) begin
            n_fail++;
            $display("FAIL reset_restart: count=%0d errs=%0d first=%0d lastpos=%0d expected 1024 0 1023", cap_n, e, fb, last_pos);
        end
    endtask

    task automatic test_start_ignored();
        bit to, relaunched; int fc, fb, e;
        clear_capture();
        pulse_start();
        for (int i = 0; i < 5000 && cap_n < 200; i++) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(to, fc);
        e = frame_errs(fb);
        n_checks++;
        if (to || cap_n !== 1024 || e !== 0 || last_cnt !== 1) begin
            n_fail++;
            $display("FAIL start_ignored: count=%0d errs=%0d last_count=%0d expected 1024 0 1", cap_n, e, last_cnt);
        end
        relaunched = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (busy) relaunched = 1;
        end
        n_checks++;
        if (relaunched !== 1'b0) begin
            n_fail++;
            $display("FAIL start_no_queue: busy seen after frame=%0d expected 0", relaunched);
        end
    endtask

    task automatic test_back_to_back();
        bit to; int fc, fb, e;
        clear_capture();
        pulse_start();
        wait_idle(to, fc);
        // Start in the very IDLE cycle after the last transfer
        clear_capture();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (to || busy !== 1'b1 || mem_read !== 1'b1 || mem_read_idx !== BASE) begin
            n_fail++;
            $display("FAIL b2b_restart: busy=%b rd=%b idx=%h expected 1 1 %h", busy, mem_read, mem_read_idx, BASE);
        end
        wait_idle(to, fc);
        e = frame_errs(fb);
        n_checks++;
        if (to || cap_n !== 1024 || e !== 0 || last_cnt !== 1) begin
            n_fail++;
            $display("FAIL b2b_frame: count=%0d errs=%0d last_count=%0d expected 1024 0 1", cap_n, e, last_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_zero_frame();
        test_pixel_first();
        test_pixel_last();
        test_stall_pattern();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
